// File: rtl/control_state_fsm.sv
// control_state_fsm: multi-cycle CPU control sequencer with retire/halt/illegal tracking and cycle/instruction counters
module control_state_fsm (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Run,
   input  logic [5:0]  Opcode,
   output logic [2:0]  State,
   output logic        InsDone,
   output logic        Halted,
   output logic        IllegalOp,
   output logic [31:0] CycleCnt,
   output logic [31:0] InsCnt
);
   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EXE = 3'b010,
      S_WB  = 3'b011,
      S_MEM = 3'b100
   } state_t;
   localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010,
                          OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010,
                          OP_SLL  = 6'b011000, OP_SLT  = 6'b100110, OP_SLTI = 6'b100111,
                          OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100,
                          OP_BNE  = 6'b110101, OP_BGTZ = 6'b110110, OP_J    = 6'b111000,
                          OP_JR   = 6'b111001, OP_JAL  = 6'b111010, OP_HALT = 6'b111111;
   state_t state_q, state_d;
   logic   is_alu, is_br, is_mem, is_jmp, retire, illegal, halt_ret, adv;
   assign is_alu   = Opcode inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT, OP_SLTI};
   assign is_br    = Opcode inside {OP_BEQ, OP_BNE, OP_BGTZ};
   assign is_mem   = Opcode inside {OP_LW, OP_SW};
   assign is_jmp   = Opcode inside {OP_J, OP_JR, OP_JAL, OP_HALT};
   assign halt_ret = (state_q == S_ID) && (Opcode == OP_HALT);
   assign adv      = Run && !Halted;
   assign State    = state_q;
   // next state, retire strobe and illegal detection from current state and opcode
   always_comb begin
      state_d = S_IF;
      retire  = 1'b0;
      illegal = 1'b0;
      case (state_q)
         S_IF:  state_d = S_ID;
         S_ID: begin
            state_d = (is_alu || is_br || is_mem) ? S_EXE : S_IF;
            retire  = is_jmp;
            illegal = !(is_alu || is_br || is_mem || is_jmp);
         end
         S_EXE: begin
            state_d = is_alu ? S_WB : is_mem ? S_MEM : S_IF;
            retire  = is_br;
            illegal = !(is_alu || is_br || is_mem);
         end
         S_MEM: begin
            state_d = (Opcode == OP_LW) ? S_WB : S_IF;
            retire  = (Opcode == OP_SW);
         end
         S_WB:  retire = 1'b1;
         default: illegal = 1'b1;
      endcase
   end
   // state, sticky flags and counters; everything holds unless advancing
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q   <= S_IF;
         InsDone   <= 1'b0;
         Halted    <= 1'b0;
         IllegalOp <= 1'b0;
         CycleCnt  <= '0;
         InsCnt    <= '0;
      end else if (adv) begin
         state_q   <= state_d;
         InsDone   <= retire;
         Halted    <= Halted | halt_ret;
         IllegalOp <= IllegalOp | illegal;
         CycleCnt  <= CycleCnt + 32'd1;
         InsCnt    <= InsCnt + {31'd0, retire};
      end else begin
         InsDone   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_control_state_fsm.sv
// tb_control_state_fsm: directed self-checking bench for control_state_fsm
module tb_control_state_fsm;
   logic        CLK = 1'b0, Reset = 1'b0, Run = 1'b0;
   logic [5:0]  Opcode = 6'd0;
   logic [2:0]  State;
   logic        InsDone, Halted, IllegalOp;
   logic [31:0] CycleCnt, InsCnt;
   int checks = 0, errors = 0;

   control_state_fsm dut (
      .CLK(CLK), .Reset(Reset), .Run(Run), .Opcode(Opcode), .State(State),
      .InsDone(InsDone), .Halted(Halted), .IllegalOp(IllegalOp),
      .CycleCnt(CycleCnt), .InsCnt(InsCnt)
   );

   always #5 CLK = ~CLK;

   logic [5:0]  mix_ops [4] = '{6'h31, 6'h30, 6'h34, 6'h3a};
   int          mix_len [4] = '{5, 4, 3, 2};
   logic [14:0] mix_seq [4] = '{{3'd0, 3'd3, 3'd4, 3'd2, 3'd1},
                                {3'd0, 3'd0, 3'd4, 3'd2, 3'd1},
                                {3'd0, 3'd0, 3'd0, 3'd2, 3'd1},
                                {3'd0, 3'd0, 3'd0, 3'd0, 3'd1}};
   logic [5:0]  cls_ops [17] = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h18, 6'h26, 6'h27,
                                 6'h30, 6'h31, 6'h34, 6'h35, 6'h36, 6'h38, 6'h39, 6'h3a};
   int          cls_len [17] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, 3, 3, 3, 2, 2, 2};

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      Run   = 1'b1;
      tick();
      Reset = 1'b0;
      Run   = 1'b0;
      checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", State); end
      checks++; if (InsDone !== 1'b0) begin errors++; $display("FAIL reset_insdone got %b exp 0", InsDone); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", Halted); end
      checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", IllegalOp); end
      checks++; if (CycleCnt !== 32'd0) begin errors++; $display("FAIL reset_cyc got %0d exp 0", CycleCnt); end
      checks++; if (InsCnt !== 32'd0) begin errors++; $display("FAIL reset_ins got %0d exp 0", InsCnt); end
   endtask

   task automatic test_add();
      logic [2:0] exp_st [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
      Opcode = 6'h00;
      Run    = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (State !== exp_st[k]) begin errors++; $display("FAIL add_state step %0d got %0d exp %0d", k, State, exp_st[k]); end
         checks++; if (InsDone !== (k == 3)) begin errors++; $display("FAIL add_insdone step %0d got %b exp %b", k, InsDone, k == 3); end
      end
      checks++; if (InsCnt !== 32'd1) begin errors++; $display("FAIL add_ins got %0d exp 1", InsCnt); end
      checks++; if (CycleCnt !== 32'd4) begin errors++; $display("FAIL add_cyc got %0d exp 4", CycleCnt); end
   endtask

   task automatic test_instr_mix();
      int cyc = 4;
      logic [14:0] seq;
      for (int i = 0; i < 4; i++) begin
         Opcode = mix_ops[i];
         seq    = mix_seq[i];
         for (int k = 0; k < mix_len[i]; k++) begin
            tick();
            checks++; if (State !== seq[3*k +: 3]) begin errors++; $display("FAIL mix_state op %h step %0d got %0d exp %0d", mix_ops[i], k, State, seq[3*k +: 3]); end
            checks++; if (InsDone !== (k == mix_len[i] - 1)) begin errors++; $display("FAIL mix_insdone op %h step %0d got %b", mix_ops[i], k, InsDone); end
         end
         cyc += mix_len[i];
         checks++; if (CycleCnt !== 32'(cyc)) begin errors++; $display("FAIL mix_cyc op %h got %0d exp %0d", mix_ops[i], CycleCnt, cyc); end
         checks++; if (InsCnt !== 32'(i + 2)) begin errors++; $display("FAIL mix_ins op %h got %0d exp %0d", mix_ops[i], InsCnt, i + 2); end
      end
   endtask

   task automatic test_opcode_classes();
      int n;
      for (int i = 0; i < 17; i++) begin
         Opcode = cls_ops[i];
         n = 0;
         do begin
            tick();
            n++;
         end while (State !== 3'd0 && n < 8);
         checks++; if (n !== cls_len[i]) begin errors++; $display("FAIL cls_len op %h got %0d exp %0d", cls_ops[i], n, cls_len[i]); end
         checks++; if (InsDone !== 1'b1) begin errors++; $display("FAIL cls_insdone op %h got %b exp 1", cls_ops[i], InsDone); end
         checks++; if (InsCnt !== 32'(i + 6)) begin errors++; $display("FAIL cls_ins op %h got %0d exp %0d", cls_ops[i], InsCnt, i + 6); end
      end
      checks++; if (CycleCnt !== 32'd78) begin errors++; $display("FAIL cls_cyc got %0d exp 78", CycleCnt); end
      checks++; if (IllegalOp !== 1'b0) begin errors++; $display("FAIL cls_illegal got %b exp 0", IllegalOp); end
   endtask

   task automatic test_halt();
      test_reset();
      Opcode = 6'h3f;
      Run    = 1'b1;
      tick();
      tick();
      checks++; if (State !== 3'd0) begin errors++; $display("FAIL halt_state got %0d exp 0", State); end
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", Halted); end
      checks++; if (InsDone !== 1'b1) begin errors++; $display("FAIL halt_insdone got %b exp 1", InsDone); end
      Opcode = 6'h00;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++; if (State !== 3'd0 || InsDone !== 1'b0) begin errors++; $display("FAIL halt_frozen cycle %0d state %0d insdone %b exp 0/0", k, State, InsDone); end
      end
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", Halted); end
      checks++; if (InsCnt !== 32'd1) begin errors++; $display("FAIL halt_ins got %0d exp 1", InsCnt); end
      checks++; if (CycleCnt !== 32'd2) begin errors++; $display("FAIL halt_cyc got %0d exp 2", CycleCnt); end
   endtask

   task automatic test_illegal();
      Opcode = 6'h2a;
      Run    = 1'b1;
      tick();
      tick();
      checks++; if (State !== 3'd0) begin errors++; $display("FAIL ill_state got %0d exp 0", State); end
      checks++; if (IllegalOp !== 1'b1) begin errors++; $display("FAIL ill_flag got %b exp 1", IllegalOp); end
      checks++; if (InsDone !== 1'b0) begin errors++; $display("FAIL ill_insdone got %b exp 0", InsDone); end
      checks++; if (InsCnt !== 32'd0) begin errors++; $display("FAIL ill_ins got %0d exp 0", InsCnt); end
      Opcode = 6'h00;
      for (int k = 0; k < 4; k++) tick();
      checks++; if (State !== 3'd0 || InsDone !== 1'b1) begin errors++; $display("FAIL ill_add state %0d insdone %b exp 0/1", State, InsDone); end
      checks++; if (InsCnt !== 32'd1) begin errors++; $display("FAIL ill_add_ins got %0d exp 1", InsCnt); end
      checks++; if (CycleCnt !== 32'd6) begin errors++; $display("FAIL ill_add_cyc got %0d exp 6", CycleCnt); end
      checks++; if (IllegalOp !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", IllegalOp); end
   endtask

   task automatic test_run_pause();
      Opcode = 6'h31;
      Run    = 1'b1;
      tick();
      tick();
      Run = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (State !== 3'd2 || CycleCnt !== 32'd8) begin errors++; $display("FAIL pause cycle %0d state %0d cyc %0d exp 2/8", k, State, CycleCnt); end
      end
      Run = 1'b1;
      tick();
      checks++; if (State !== 3'd4) begin errors++; $display("FAIL pause_resume got %0d exp 4", State); end
      checks++; if (CycleCnt !== 32'd9) begin errors++; $display("FAIL pause_cyc got %0d exp 9", CycleCnt); end
   endtask

   task automatic test_reset_abort();
      Run   = 1'b0;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      checks++; if (State !== 3'd0 || InsDone !== 1'b0) begin errors++; $display("FAIL abort state %0d insdone %b exp 0/0", State, InsDone); end
      checks++; if (IllegalOp !== 1'b0 || Halted !== 1'b0) begin errors++; $display("FAIL abort_flags ill %b halt %b exp 0/0", IllegalOp, Halted); end
      checks++; if (CycleCnt !== 32'd0 || InsCnt !== 32'd0) begin errors++; $display("FAIL abort_cnt cyc %0d ins %0d exp 0/0", CycleCnt, InsCnt); end
   endtask

   task automatic test_wrap();
      Run = 1'b0;
      force dut.CycleCnt = 32'hFFFF_FFFF;
      #1;
      release dut.CycleCnt;
      Run = 1'b1;
      tick();
      checks++; if (CycleCnt !== 32'd0) begin errors++; $display("FAIL wrap_cyc got %h exp 00000000", CycleCnt); end
      checks++; if (State !== 3'd1) begin errors++; $display("FAIL wrap_state got %0d exp 1", State); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_instr_mix();
      test_opcode_classes();
      test_halt();
      test_reset();
      test_illegal();
      test_run_pause();
      test_reset_abort();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
